// File: rtl/cordic_bus_bridge_if.sv
// Host-side register bus of the CORDIC bridge: single-outstanding valid/ready
// request/response channel plus the sticky interrupt line.
interface cordic_bus_bridge_if #(
  parameter int p_WIDTH = 32
);
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [2:0]         req_addr;
  logic [p_WIDTH-1:0] req_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [p_WIDTH-1:0] rsp_rdata;
  logic               rsp_err;
  logic               host_irq;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, host_irq
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, host_irq
  );
endinterface

// File: rtl/cordic_bus_bridge.sv
// Bus-side endpoint of the CORDIC controller: operand/control registers for the
// host, controller flag write-back merge, result readback and sticky host IRQ.
module cordic_bus_bridge #(
  parameter int p_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  cordic_bus_bridge_if.slave  bus,
  output logic [p_WIDTH-1:0]  xInput,
  output logic [p_WIDTH-1:0]  yInput,
  output logic [p_WIDTH-1:0]  zInput,
  output logic [p_WIDTH-1:0]  controlRegisterInput,
  input  logic [p_WIDTH-1:0]  xResult,
  input  logic [p_WIDTH-1:0]  yResult,
  input  logic [p_WIDTH-1:0]  zResult,
  input  logic [p_WIDTH-1:0]  controlRegisterOutput,
  input  logic                controlRegisterWriteEnable,
  input  logic                interrupt
);

  typedef enum logic {
    s_idle,
    s_resp
  } state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic               busy;
  logic               wr_err;
  logic               wr_ok;
  logic [1:0]         w1c;
  logic [p_WIDTH-1:0] rd_mux;
  logic               interrupt_q;
  logic               irq_pending;
  logic               err_pending;

  // NOTE: every flop uses non-blocking assignments so all registers update
  // together on the edge regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= s_idle;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment up front keeps this block purely combinational
  // on every path; leaving it out would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      s_idle:  if (bus.req_valid) state_nxt = s_resp;
      s_resp:  if (bus.rsp_ready) state_nxt = s_idle;
      default: state_nxt = s_idle;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == s_idle);
    bus.rsp_valid = (state == s_resp);
  end

  assign accept = bus.req_ready & bus.req_valid;
  // Busy is judged on the shadow as it stood before this cycle's update.
  assign busy   = ~controlRegisterInput[16];

  always_comb begin
    wr_err = 1'b0;
    case (bus.req_addr)
      3'd0, 3'd1, 3'd2: wr_err = busy;
      3'd3:             wr_err = busy & bus.req_wdata[0];
      3'd4, 3'd5, 3'd6: wr_err = 1'b1;
      default:          wr_err = 1'b0;
    endcase
  end

  assign wr_ok = accept & bus.req_write & ~wr_err;
  assign w1c   = (wr_ok && bus.req_addr == 3'd7) ? bus.req_wdata[1:0] : 2'b00;

  always_comb begin
    rd_mux = '0;
    case (bus.req_addr)
      3'd0: rd_mux = xInput;
      3'd1: rd_mux = yInput;
      3'd2: rd_mux = zInput;
      3'd3: rd_mux = controlRegisterInput;
      3'd4: rd_mux = xResult;
      3'd5: rd_mux = yResult;
      3'd6: rd_mux = zResult;
      default: begin
        rd_mux[0] = irq_pending;
        rd_mux[1] = err_pending;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else if (accept) begin
      bus.rsp_rdata <= bus.req_write ? '0 : rd_mux;
      bus.rsp_err   <= bus.req_write & wr_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xInput <= '0;
      yInput <= '0;
      zInput <= '0;
    end else if (wr_ok) begin
      case (bus.req_addr)
        3'd0:    xInput <= bus.req_wdata;
        3'd1:    yInput <= bus.req_wdata;
        3'd2:    zInput <= bus.req_wdata;
        default: ;
      endcase
    end
  end

  // Host owns [15:0] (start/stop self-clear), controller owns the upper flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      controlRegisterInput     <= '0;
      controlRegisterInput[16] <= 1'b1;
    end else begin
      controlRegisterInput[1:0] <= 2'b00;
      if (wr_ok && bus.req_addr == 3'd3)
        controlRegisterInput[15:0] <= bus.req_wdata[15:0];
      if (controlRegisterWriteEnable)
        controlRegisterInput[p_WIDTH-1:16] <= controlRegisterOutput[p_WIDTH-1:16];
    end
  end

  // Set events dominate a simultaneous write-1-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      interrupt_q <= 1'b0;
      irq_pending <= 1'b0;
      err_pending <= 1'b0;
    end else begin
      interrupt_q <= interrupt;
      irq_pending <= (interrupt & ~interrupt_q) | (irq_pending & ~w1c[0]);
      err_pending <= (accept & bus.req_write & wr_err) | (err_pending & ~w1c[1]);
    end
  end

  assign bus.host_irq = irq_pending | err_pending;

endmodule

// File: tb/tb_cordic_bus_bridge.sv
// Self-checking bench for cordic_bus_bridge: directed scenarios pinned with
// literal values, then randomized traffic against a behavioural register model.
module tb_cordic_bus_bridge;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] xInput, yInput, zInput, controlRegisterInput;
  logic [W-1:0] xResult, yResult, zResult, controlRegisterOutput;
  logic         controlRegisterWriteEnable;
  logic         interrupt;

  int n_vec = 0;
  int n_bad = 0;

  cordic_bus_bridge_if #(.p_WIDTH(W)) bus ();

  cordic_bus_bridge #(.p_WIDTH(W)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .bus                        (bus),
    .xInput                     (xInput),
    .yInput                     (yInput),
    .zInput                     (zInput),
    .controlRegisterInput       (controlRegisterInput),
    .xResult                    (xResult),
    .yResult                    (yResult),
    .zResult                    (zResult),
    .controlRegisterOutput      (controlRegisterOutput),
    .controlRegisterWriteEnable (controlRegisterWriteEnable),
    .interrupt                  (interrupt)
  );

  always #5 clk = ~clk;

  // Behavioural register-file view of the bridge.
  logic [W-1:0] m_op [0:2];
  logic [W-1:0] m_ctrl;
  logic [W-1:0] m_rdata;
  logic         m_rerr, m_pend, m_irq, m_err, m_int_prev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_op[i] = '0;
    m_ctrl     = 32'h0001_0000;
    m_rdata    = '0;
    m_rerr     = 1'b0;
    m_pend     = 1'b0;
    m_irq      = 1'b0;
    m_err      = 1'b0;
    m_int_prev = 1'b0;
  endtask

  // Applies the register-map rules for one clock edge using the sampled inputs.
  task automatic model_step();
    logic         acc, wr, bad, clr7;
    logic [2:0]   a;
    logic [W-1:0] d, rd, nctrl;
    acc = !m_pend && bus.req_valid;
    wr  = bus.req_write;
    a   = bus.req_addr;
    d   = bus.req_wdata;
    bad = 1'b0;
    rd  = '0;
    if (acc && wr)
      bad = (a >= 3'd4 && a <= 3'd6) || (a <= 3'd2 && !m_ctrl[16]) ||
            (a == 3'd3 && d[0] && !m_ctrl[16]);
    if (acc && !wr) begin
      if (a <= 3'd2)      rd = m_op[a[1:0]];
      else if (a == 3'd3) rd = m_ctrl;
      else if (a == 3'd4) rd = xResult;
      else if (a == 3'd5) rd = yResult;
      else if (a == 3'd6) rd = zResult;
      else begin rd[0] = m_irq; rd[1] = m_err; end
    end
    clr7  = acc && wr && !bad && a == 3'd7;
    nctrl = {m_ctrl[W-1:2], 2'b00};
    if (acc && wr && !bad && a == 3'd3) nctrl[15:0] = d[15:0];
    if (controlRegisterWriteEnable) nctrl[W-1:16] = controlRegisterOutput[W-1:16];
    if (acc && wr && !bad && a <= 3'd2) m_op[a[1:0]] = d;
    m_irq      = (interrupt && !m_int_prev) || (m_irq && !(clr7 && d[0]));
    m_err      = (acc && wr && bad) || (m_err && !(clr7 && d[1]));
    m_int_prev = interrupt;
    m_ctrl     = nctrl;
    if (acc) begin
      m_rdata = wr ? '0 : rd;
      m_rerr  = bad;
      m_pend  = 1'b1;
    end else if (m_pend && bus.rsp_ready) begin
      m_pend = 1'b0;
    end
  endtask

  // Advance one edge, step the model, and leave time 1 unit after the edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("req_ready", bus.req_ready, !m_pend);
      check("rsp_valid", bus.rsp_valid, m_pend);
      if (m_pend) begin
        check("rsp_rdata", bus.rsp_rdata, m_rdata);
        check("rsp_err", bus.rsp_err, m_rerr);
      end
      check("host_irq", bus.host_irq, m_irq | m_err);
      check("xInput", xInput, m_op[0]);
      check("yInput", yInput, m_op[1]);
      check("zInput", zInput, m_op[2]);
      check("ctrl", controlRegisterInput, m_ctrl);
    end
  end

  task automatic issue(input logic wr, input logic [2:0] a, input logic [W-1:0] d);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && n < 50) begin
      cycle();
      n++;
    end
    check("accept_wait", bus.req_ready, 1);
    cycle();
    bus.req_valid = 1'b0;
    check("rsp_latency", bus.rsp_valid, 1);
  endtask

  task automatic bus_op(input logic wr, input logic [2:0] a, input logic [W-1:0] d,
                        output logic [W-1:0] rd, output logic er);
    issue(wr, a, d);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    cycle();
  endtask

  task automatic ctrl_wb(input logic [W-1:0] v);
    controlRegisterOutput      = v;
    controlRegisterWriteEnable = 1'b1;
    cycle();
    controlRegisterWriteEnable = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         er;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    xResult = 32'h1111_1111;
    yResult = 32'h2222_2222;
    zResult = 32'h3333_3333;
    controlRegisterOutput      = '0;
    controlRegisterWriteEnable = 1'b0;
    interrupt = 1'b0;
    model_reset();

    #1 rst = 1'b1;
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_ctrl", controlRegisterInput, 32'h0001_0000);
    check("rst_host_irq", bus.host_irq, 0);
    cycle();
    cycle();
    rst = 1'b0;

    // Operand write and readback.
    bus_op(1'b1, 3'd0, 32'h0000_1000, rd, er);
    check("wr_x_err", er, 0);
    bus_op(1'b0, 3'd0, '0, rd, er);
    check("rd_x", rd, 32'h0000_1000);
    bus_op(1'b0, 3'd5, '0, rd, er);
    check("rd_yresult", rd, 32'h2222_2222);

    // Start pulse lasts one cycle, upper host bits persist.
    issue(1'b1, 3'd3, 32'h0000_0A05);
    check("start_pulse", controlRegisterInput, 32'h0001_0A05);
    cycle();
    check("start_clear", controlRegisterInput, 32'h0001_0A04);

    // Controller drops ready; operand writes now rejected.
    ctrl_wb(32'h0000_1234);
    check("ready_low", controlRegisterInput, 32'h0000_0A04);
    bus_op(1'b1, 3'd1, 32'hDEAD_BEEF, rd, er);
    check("busy_err", er, 1);
    check("y_kept", yInput, 0);
    check("err_irq", bus.host_irq, 1);

    // Stop is always accepted; result writes always rejected.
    issue(1'b1, 3'd3, 32'h0000_0002);
    check("stop_err", bus.rsp_err, 0);
    check("stop_pulse", controlRegisterInput, 32'h0000_0002);
    cycle();
    check("stop_clear", controlRegisterInput, 32'h0000_0000);
    bus_op(1'b1, 3'd5, 32'h1, rd, er);
    check("ro_err", er, 1);

    // Interrupt edge, W1C of each pending bit.
    interrupt = 1'b1;
    cycle(); cycle(); cycle();
    interrupt = 1'b0;
    cycle();
    bus_op(1'b0, 3'd7, '0, rd, er);
    check("irq_status", rd, 32'h3);
    bus_op(1'b1, 3'd7, 32'h1, rd, er);
    bus_op(1'b0, 3'd7, '0, rd, er);
    check("irq_w1c", rd, 32'h2);
    bus_op(1'b1, 3'd7, 32'h2, rd, er);
    check("irq_all_clear", bus.host_irq, 0);

    // Rising edge coincident with the clear wins.
    interrupt = 1'b1;
    issue(1'b1, 3'd7, 32'h1);
    interrupt = 1'b0;
    cycle();
    bus_op(1'b0, 3'd7, '0, rd, er);
    check("irq_set_wins", rd, 32'h1);
    bus_op(1'b1, 3'd7, 32'h1, rd, er);

    // Response held under backpressure, then reset mid-response.
    ctrl_wb(32'h0001_0000);
    bus_op(1'b1, 3'd2, 32'h5555_AAAA, rd, er);
    bus.rsp_ready = 1'b0;
    issue(1'b0, 3'd2, '0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 3'd0;
    bus.req_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_rdata", bus.rsp_rdata, 32'h5555_AAAA);
      check("hold_ready", bus.req_ready, 0);
    end
    rst = 1'b1;
    #1;
    check("mid_rst_req_ready", bus.req_ready, 1);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_rdata", bus.rsp_rdata, 0);
    check("mid_rst_zinput", zInput, 0);
    check("mid_rst_ctrl", controlRegisterInput, 32'h0001_0000);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    cycle();
    rst = 1'b0;

    // Host and controller writes to the shadow in the same cycle.
    controlRegisterOutput      = 32'hABCD_0000;
    controlRegisterWriteEnable = 1'b1;
    issue(1'b1, 3'd3, 32'h0000_F0FB);
    controlRegisterWriteEnable = 1'b0;
    check("merge_pulse", controlRegisterInput, 32'hABCD_F0FB);
    cycle();
    check("merge_settled", controlRegisterInput, 32'hABCD_F0F8);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      bus.req_valid = ($urandom_range(0, 9) < 6);
      bus.req_write = 1'($urandom_range(0, 1));
      bus.req_addr  = 3'($urandom_range(0, 7));
      bus.req_wdata = $urandom;
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      controlRegisterWriteEnable = ($urandom_range(0, 9) == 0);
      controlRegisterOutput      = $urandom;
      if ($urandom_range(0, 7) == 0) interrupt = ~interrupt;
      xResult = $urandom;
      yResult = $urandom;
      zResult = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cordic_bus_bridge.md
Name: cordic_bus_bridge

Overview:
- Bus-side endpoint of the CORDIC bus interface; counterpart of the controller modport.
- Exposes a single-outstanding, valid/ready memory-mapped register port to the host.
- Drives the X/Y/Z operand registers and the control-register shadow toward the controller.
- Merges controller flag write-backs into that shadow, returns results, and turns the controller interrupt into a sticky host IRQ.

Parameters:
- p_WIDTH, 32, datapath width of the operand, result and control registers (minimum 32, for the flag field).

Ports:
- clk  input  1  clock; every flop in the block is clocked on its rising edge.
- rst  input  1  reset; asynchronous and active-high.
- req_valid  input  1  host request valid.
- req_ready  output  1  bridge can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  3  word address.
- req_wdata  input  p_WIDTH  write data.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  host accepts the response.
- rsp_rdata  output  p_WIDTH  read data; 0 for writes.
- rsp_err  output  1  request rejected.
- host_irq  output  1  sticky interrupt to the host.
- xInput  output  p_WIDTH  X operand to the controller.
- yInput  output  p_WIDTH  Y operand to the controller.
- zInput  output  p_WIDTH  Z operand to the controller.
- controlRegisterInput  output  p_WIDTH  control/flag shadow to the controller.
- xResult  input  p_WIDTH  X result from the controller.
- yResult  input  p_WIDTH  Y result from the controller.
- zResult  input  p_WIDTH  Z result from the controller.
- controlRegisterOutput  input  p_WIDTH  control/flag word from the controller.
- controlRegisterWriteEnable  input  1  controller flag write-back strobe.
- interrupt  input  1  controller interrupt (level).

Behaviour:
Address map:
- 0/1/2: X/Y/Z operand, RW.
- 3: CTRL shadow, RW.
  - Host writes affect bits [15:0] only.
  - Reads return all bits.
- 4/5/6: xResult/yResult/zResult, RO, read live on the accept cycle.
- 7: IRQ status.
  - bit0 = irq_pending, bit1 = err_pending, W1C; other bits read 0.

Handshake FSM, two states:
- IDLE: req_ready=1. When req_valid, the request is accepted; the write effect (if any) and rsp_rdata/rsp_err are registered; next state RESP.
- RESP: req_ready=0, rsp_valid=1, rsp_rdata/rsp_err held stable. Return to IDLE on rsp_ready.
- Latency: accept to rsp_valid is exactly 1 cycle. Back-to-back throughput is 1 request per 2 cycles.

Error rules (the write has no effect, rsp_err=1):
- Write to address 4–6.
- Write to address 0–2 while ready flag shadow[16]=0.
- Write to address 3 with wdata[0]=1 (start) while shadow[16]=0.
- Writes to address 3 with only stop (bit1) set are always accepted.
- Reads never error.

CTRL shadow:
- Bits 0 (start) and 1 (stop) are pulses: set by an accepted write, cleared automatically on the next cycle. controlRegisterInput[0] is therefore high for exactly one cycle per start.
- Bits [15:2] hold the host-written value.
- When controlRegisterWriteEnable=1, shadow[31:16] <= controlRegisterOutput[31:16]. Host writes never modify [31:16].
- Host write and controller write-back in the same cycle: both apply (host owns [15:0], controller owns [31:16]).
- Busy checks use the shadow value before that cycle's update.

IRQ:
- interrupt is registered once to form an edge detector. A rising edge sets irq_pending.
- Any rsp_err sets err_pending on the accept cycle.
- host_irq = irq_pending | err_pending.
- W1C at address 7: a set event in the same cycle as a clear wins; the bit stays 1.

Reset (asynchronous, rst=1):
- FSM -> IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0.
- xInput/yInput/zInput = 0.
- controlRegisterInput = 0x0001_0000 (ready flag set).
- irq_pending = 0, err_pending = 0, host_irq = 0, edge register = 0.
- Reset while in RESP drops the response; no partial write survives.

Test Plan:
- Reset, then write X=0x0000_1000 to addr 0, read addr 0 -> write response err=0; read returns 0x0000_1000; rsp_valid rises 1 cycle after accept.
- Write addr 3 = 0x0000_0A05 -> controlRegisterInput[0]=1 for exactly one cycle, then [15:0]=0x0A04. Controller then pulses controlRegisterWriteEnable with 0x0000_xxxx (ready=0). Write to addr 1 -> rsp_err=1, Y unchanged, host_irq=1.
- While ready=0, write addr 3 = 0x2 (stop) -> err=0 and a one-cycle stop pulse. Write to addr 5 -> err=1.
- Pulse interrupt high for 3 cycles -> irq_pending=1 and stays high. Write addr 7 = 0x1 -> cleared. Rising edge of interrupt in the W1C accept cycle -> bit stays 1.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, a new req_valid is not accepted. Assert rst mid-RESP -> all outputs at reset values immediately.
- Host write addr 3 and controlRegisterWriteEnable with 0xABCD_0000 in the same cycle -> shadow = 0xABCD_<host [15:2] bits, start/stop bits 0 after the one-cycle pulse>.
